// File: rtl/axi_llc_refill_r_sink.sv
// LLC refill R-channel sink: streams one cache-line burst of R beats into data
// storage, then forwards the refill descriptor to the read/write units.
package axi_llc_pkg;
   typedef struct packed {
      int unsigned SetAssociativity;
      int unsigned NoBlocks;
      int unsigned BlockSize;
      int unsigned IndexLength;
      int unsigned BlockOffsetLength;
      int unsigned ByteOffsetLength;
   } llc_cfg_t;

   typedef struct packed {
      int unsigned MstPortIdWidth;
   } llc_axi_cfg_t;

   localparam llc_cfg_t DefaultCfg = '{
      SetAssociativity:  32'd4,
      NoBlocks:          32'd4,
      BlockSize:         32'd64,
      IndexLength:       32'd8,
      BlockOffsetLength: 32'd2,
      ByteOffsetLength:  32'd3
   };

   localparam llc_axi_cfg_t DefaultAxiCfg = '{MstPortIdWidth: 32'd4};

   typedef struct packed {
      logic        refill;
      logic [31:0] a_x_addr;
      logic [3:0]  way_ind;
   } default_desc_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } default_r_chan_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

module axi_llc_refill_r_sink #(
   parameter axi_llc_pkg::llc_cfg_t     Cfg    = axi_llc_pkg::DefaultCfg,
   parameter axi_llc_pkg::llc_axi_cfg_t AxiCfg = axi_llc_pkg::DefaultAxiCfg,
   parameter type desc_t   = axi_llc_pkg::default_desc_t,
   parameter type r_chan_t = axi_llc_pkg::default_r_chan_t
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  desc_t                            desc_i,
   input  logic                             desc_valid_i,
   output logic                             desc_ready_o,
   output desc_t                            desc_o,
   output logic                             desc_valid_o,
   input  logic                             desc_ready_i,
   input  r_chan_t                          r_chan_i,
   input  logic                             r_valid_i,
   output logic                             r_ready_o,
   output logic [Cfg.BlockSize-1:0]         wr_data_o,
   output logic [Cfg.IndexLength-1:0]       wr_index_o,
   output logic [Cfg.BlockOffsetLength-1:0] wr_block_o,
   output logic [Cfg.SetAssociativity-1:0]  wr_way_o,
   output logic                             wr_valid_o,
   input  logic                             wr_ready_i,
   output logic                             err_o
);
   localparam int unsigned AddrOffset = Cfg.BlockOffsetLength + Cfg.ByteOffsetLength;
   localparam int unsigned CntW = (Cfg.BlockOffsetLength > 0) ? Cfg.BlockOffsetLength : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(Cfg.NoBlocks - 1);

   typedef enum logic [1:0] {IDLE, REFILL, SEND} state_e;

   state_e          state_q, state_d;
   desc_t           desc_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            load_desc;
   logic            last_beat;

   assign last_beat = (cnt_q == LastCnt);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = 1'b0;
      load_desc    = 1'b0;
      desc_ready_o = 1'b0;
      desc_valid_o = 1'b0;
      r_ready_o    = 1'b0;
      wr_valid_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            desc_ready_o = 1'b1;
            if (desc_valid_i) begin
               load_desc = 1'b1;
               if (desc_i.refill) begin
                  cnt_d   = '0;
                  state_d = REFILL;
               end else begin
                  state_d = SEND;
               end
            end
         end
         REFILL: begin
            // R and the storage write port handshake together; nothing is buffered.
            wr_valid_o = r_valid_i;
            r_ready_o  = wr_ready_i;
            if (r_valid_i && wr_ready_i) begin
               err_d = (r_chan_i.resp != axi_llc_pkg::RESP_OKAY) || (r_chan_i.last != last_beat);
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = SEND;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         SEND: begin
            desc_valid_o = 1'b1;
            if (desc_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         desc_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (load_desc) begin
            desc_q <= desc_i;
         end
      end
   end

   assign desc_o     = desc_q;
   assign err_o      = err_q;
   assign wr_data_o  = r_chan_i.data;
   assign wr_index_o = desc_q.a_x_addr[AddrOffset +: Cfg.IndexLength];
   assign wr_block_o = cnt_q;
   assign wr_way_o   = desc_q.way_ind;

   // Fields of the generic channel types that this block never looks at.
   logic unused_bits;
   assign unused_bits = ^{AxiCfg.MstPortIdWidth, r_chan_i};
endmodule

// File: tb/tb_axi_llc_refill_r_sink.sv
// Bench for axi_llc_refill_r_sink: directed scenarios plus randomized lines
// checked against a line-level model of the refill sink.
module tb_axi_llc_refill_r_sink;
   localparam axi_llc_pkg::llc_cfg_t Cfg = '{
      SetAssociativity:  32'd4,
      NoBlocks:          32'd4,
      BlockSize:         32'd64,
      IndexLength:       32'd8,
      BlockOffsetLength: 32'd2,
      ByteOffsetLength:  32'd3
   };
   localparam axi_llc_pkg::llc_axi_cfg_t AxiCfg = '{MstPortIdWidth: 32'd4};
   localparam int NB = 4;

   typedef struct packed {
      logic [3:0]  x_id;
      logic        refill;
      logic [31:0] a_x_addr;
      logic [3:0]  way_ind;
   } desc_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  index;
      logic [1:0]  block;
      logic [3:0]  way;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_i;
   desc_t       desc_i, desc_o;
   logic        desc_valid_i, desc_ready_o, desc_valid_o, desc_ready_i;
   r_chan_t     r_chan_i;
   logic        r_valid_i, r_ready_o;
   logic [63:0] wr_data_o;
   logic [7:0]  wr_index_o;
   logic [1:0]  wr_block_o;
   logic [3:0]  wr_way_o;
   logic        wr_valid_o, wr_ready_i, err_o;

   always #5 clk = ~clk;

   axi_llc_refill_r_sink #(
      .Cfg(Cfg), .AxiCfg(AxiCfg), .desc_t(desc_t), .r_chan_t(r_chan_t)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .desc_i(desc_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
      .desc_o(desc_o), .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
      .r_chan_i(r_chan_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
      .wr_data_o(wr_data_o), .wr_index_o(wr_index_o), .wr_block_o(wr_block_o),
      .wr_way_o(wr_way_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
      .err_o(err_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_cycles = 0;
   int rr_high = 0;
   wr_t got_wr[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_valid_o && wr_ready_i) got_wr.push_back({wr_data_o, wr_index_o, wr_block_o, wr_way_o});
      if (err_o) err_cycles <= err_cycles + 1;
      if (r_ready_o) rr_high <= rr_high + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
      $fatal(1);
   end

   logic [63:0] beat_data[NB];
   logic [1:0]  beat_resp[NB];
   logic        beat_last[NB];

   int    t_hs, t_out, mirror_bad, hold_bad;
   bit    timeout;
   desc_t out_desc;
   logic  out_rdy;

   // Line-level model: beat i lands in block i of the addressed set and way.
   function automatic wr_t exp_wr(desc_t d, int i);
      wr_t w;
      w.data  = beat_data[i];
      w.index = 8'(d.a_x_addr >> 5);
      w.block = 2'(i);
      w.way   = d.way_ind;
      return w;
   endfunction

   function automatic int exp_errs();
      int n = 0;
      for (int i = 0; i < NB; i++)
         if (beat_resp[i] != 2'b00 || beat_last[i] != (i == NB - 1)) n++;
      return n;
   endfunction

   task automatic clean_beats(input logic [63:0] base);
      for (int i = 0; i < NB; i++) begin
         beat_data[i] = base + 64'(i);
         beat_resp[i] = 2'b00;
         beat_last[i] = (i == NB - 1);
      end
   endtask

   function automatic desc_t rand_desc(input logic refill);
      desc_t d;
      d.x_id     = 4'($urandom);
      d.refill   = refill;
      d.a_x_addr = $urandom;
      d.way_ind  = 4'b0001 << $urandom_range(3);
      return d;
   endfunction

   // Drives one descriptor, its beats (if refill) and collects the outgoing descriptor.
   task automatic run_line(input desc_t d, input int gap_pct, input int rdy_pct, input bit toggle, input int hold);
      int  budget;
      bit  acc;
      timeout    = 0;
      mirror_bad = 0;
      hold_bad   = 0;
      desc_i       = d;
      desc_valid_i = 1'b1;
      budget       = 0;
      forever begin
         @(negedge clk);
         if (desc_ready_o) break;
         if (++budget > 50) begin timeout = 1; break; end
      end
      t_hs = cyc;
      @(posedge clk); #1;
      desc_valid_i = 1'b0;
      if (d.refill) begin
         for (int i = 0; i < NB; i++) begin
            acc    = 0;
            budget = 0;
            while (!acc && !timeout) begin
               r_valid_i  = ($urandom_range(99) >= gap_pct);
               wr_ready_i = toggle ? ~wr_ready_i : ($urandom_range(99) < rdy_pct);
               r_chan_i   = '{id: 4'($urandom), data: beat_data[i], resp: beat_resp[i], last: beat_last[i]};
               @(negedge clk);
               if (r_ready_o !== wr_ready_i) mirror_bad++;
               acc = r_valid_i && wr_ready_i;
               @(posedge clk); #1;
               if (++budget > 200) timeout = 1;
            end
         end
      end
      r_valid_i    = 1'b0;
      desc_ready_i = (hold == 0);
      budget       = 0;
      forever begin
         @(negedge clk);
         if (desc_valid_o) break;
         if (++budget > 50) begin timeout = 1; break; end
      end
      t_out    = cyc;
      out_desc = desc_o;
      out_rdy  = desc_ready_o;
      repeat (hold) begin
         @(negedge clk);
         if (!(desc_valid_o === 1'b1 && desc_o === out_desc)) hold_bad++;
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         desc_ready_i = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      desc_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; desc_valid_i = 1'b0; desc_ready_i = 1'b1; desc_i = rand_desc(1'b1);
      r_valid_i = 1'b1; wr_ready_i = 1'b1; r_chan_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (desc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_desc_ready: got %b expected 1", desc_ready_o); end
      checks++; if (desc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_desc_valid: got %b expected 0", desc_valid_o); end
      checks++; if (r_ready_o !== 1'b0) begin errors++; $display("FAIL reset_r_ready: got %b expected 0", r_ready_o); end
      checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
      checks++; if (desc_o !== '0) begin errors++; $display("FAIL reset_desc_o: got %h expected 0", desc_o); end
      @(posedge clk); #1;
      rst_i = 1'b0; r_valid_i = 1'b0; desc_ready_i = 1'b0;
   endtask

   task automatic test_bypass();
      desc_t d = rand_desc(1'b0);
      int wb = got_wr.size();
      int rb;
      wr_ready_i = 1'b1;
      @(posedge clk); #1;
      rb = rr_high;
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (timeout) begin errors++; $display("FAIL bypass_timeout: got timeout expected descriptor"); end
      checks++; if (t_out - t_hs != 1) begin errors++; $display("FAIL bypass_latency: got %0d expected 1", t_out - t_hs); end
      checks++; if (out_desc !== d) begin errors++; $display("FAIL bypass_desc: got %h expected %h", out_desc, d); end
      checks++; if (out_rdy !== 1'b0) begin errors++; $display("FAIL bypass_next_ready: got %b expected 0", out_rdy); end
      checks++; if (got_wr.size() != wb) begin errors++; $display("FAIL bypass_writes: got %0d expected 0", got_wr.size() - wb); end
      checks++; if (rr_high != rb) begin errors++; $display("FAIL bypass_r_ready: got %0d high cycles expected 0", rr_high - rb); end
   endtask

   task automatic test_full_refill();
      desc_t d = rand_desc(1'b1);
      int wb = got_wr.size();
      int eb = err_cycles;
      d.a_x_addr = {d.a_x_addr[31:13], 8'h12, d.a_x_addr[4:0]};
      d.way_ind  = 4'b0100;
      clean_beats(64'hA0);
      wr_ready_i = 1'b1;
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (timeout) begin errors++; $display("FAIL full_timeout: got timeout expected descriptor"); end
      checks++; if (t_out - t_hs != NB + 1) begin errors++; $display("FAIL full_latency: got %0d expected %0d", t_out - t_hs, NB + 1); end
      checks++; if (got_wr.size() - wb != NB) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_wr.size() - wb, NB); end
      for (int i = 0; i < NB && wb + i < got_wr.size(); i++) begin
         checks++;
         if (got_wr[wb + i] !== exp_wr(d, i)) begin errors++; $display("FAIL full_wr%0d: got %h expected %h", i, got_wr[wb + i], exp_wr(d, i)); end
      end
      checks++; if (err_cycles != eb) begin errors++; $display("FAIL full_err: got %0d expected 0", err_cycles - eb); end
      checks++; if (out_desc !== d) begin errors++; $display("FAIL full_desc: got %h expected %h", out_desc, d); end
      checks++; if (mirror_bad != 0) begin errors++; $display("FAIL full_mirror: got %0d expected 0", mirror_bad); end
   endtask

   task automatic test_backpressure();
      desc_t d = rand_desc(1'b1);
      int wb = got_wr.size();
      clean_beats(64'hB0);
      wr_ready_i = 1'b1;
      run_line(d, 0, 100, 1'b1, 3);
      checks++; if (timeout) begin errors++; $display("FAIL bp_timeout: got timeout expected descriptor"); end
      checks++; if (mirror_bad != 0) begin errors++; $display("FAIL bp_mirror: got %0d expected 0", mirror_bad); end
      checks++; if (got_wr.size() - wb != NB) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_wr.size() - wb, NB); end
      for (int i = 0; i < NB && wb + i < got_wr.size(); i++) begin
         checks++;
         if (got_wr[wb + i] !== exp_wr(d, i)) begin errors++; $display("FAIL bp_wr%0d: got %h expected %h", i, got_wr[wb + i], exp_wr(d, i)); end
      end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
      checks++; if (out_desc !== d) begin errors++; $display("FAIL bp_desc: got %h expected %h", out_desc, d); end
   endtask

   task automatic test_err_resp();
      desc_t d = rand_desc(1'b1);
      int wb = got_wr.size();
      int eb = err_cycles;
      clean_beats(64'hC0);
      beat_resp[2] = 2'b10;
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (err_cycles - eb != 1) begin errors++; $display("FAIL resp_err: got %0d cycles expected 1", err_cycles - eb); end
      checks++; if (got_wr.size() - wb != NB) begin errors++; $display("FAIL resp_count: got %0d expected %0d", got_wr.size() - wb, NB); end
      checks++; if (timeout || out_desc !== d) begin errors++; $display("FAIL resp_desc: got %h expected %h", out_desc, d); end
   endtask

   task automatic test_last_err();
      desc_t d = rand_desc(1'b1);
      int eb = err_cycles;
      clean_beats(64'hD0);
      beat_last[1] = 1'b1;
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (err_cycles - eb != 1) begin errors++; $display("FAIL early_last_err: got %0d cycles expected 1", err_cycles - eb); end
      checks++; if (timeout || out_desc !== d) begin errors++; $display("FAIL early_last_desc: got %h expected %h", out_desc, d); end
      d  = rand_desc(1'b1);
      eb = err_cycles;
      clean_beats(64'hE0);
      beat_last[NB - 1] = 1'b0;
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (err_cycles - eb != 1) begin errors++; $display("FAIL missing_last_err: got %0d cycles expected 1", err_cycles - eb); end
      checks++; if (timeout || out_desc !== d) begin errors++; $display("FAIL missing_last_desc: got %h expected %h", out_desc, d); end
   endtask

   task automatic test_reset_mid();
      desc_t d = rand_desc(1'b1);
      int wb, vcnt;
      clean_beats(64'hF0);
      desc_i = d; desc_valid_i = 1'b1;
      @(posedge clk); #1;
      desc_valid_i = 1'b0; wr_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r_valid_i = 1'b1;
         r_chan_i  = '{id: 4'h0, data: beat_data[i], resp: 2'b00, last: 1'b0};
         @(posedge clk); #1;
      end
      rst_i = 1'b1;
      @(negedge clk);
      checks++; if (r_ready_o !== 1'b0) begin errors++; $display("FAIL mid_r_ready: got %b expected 0", r_ready_o); end
      checks++; if (wr_valid_o !== 1'b0) begin errors++; $display("FAIL mid_wr_valid: got %b expected 0", wr_valid_o); end
      checks++; if (desc_ready_o !== 1'b1) begin errors++; $display("FAIL mid_desc_ready: got %b expected 1", desc_ready_o); end
      checks++; if (desc_o !== '0) begin errors++; $display("FAIL mid_desc_o: got %h expected 0", desc_o); end
      @(posedge clk); #1;
      rst_i = 1'b0; r_valid_i = 1'b0; desc_ready_i = 1'b1;
      vcnt = 0;
      repeat (4) begin @(negedge clk); if (desc_valid_o !== 1'b0) vcnt++; end
      checks++; if (vcnt != 0) begin errors++; $display("FAIL mid_no_desc: got %0d valid cycles expected 0", vcnt); end
      @(posedge clk); #1;
      d  = rand_desc(1'b1);
      wb = got_wr.size();
      clean_beats(64'h1F0);
      run_line(d, 0, 100, 1'b0, 0);
      checks++; if (got_wr.size() - wb != NB) begin errors++; $display("FAIL mid_after_count: got %0d expected %0d", got_wr.size() - wb, NB); end
      for (int i = 0; i < NB && wb + i < got_wr.size(); i++) begin
         checks++;
         if (got_wr[wb + i] !== exp_wr(d, i)) begin errors++; $display("FAIL mid_after_wr%0d: got %h expected %h", i, got_wr[wb + i], exp_wr(d, i)); end
      end
   endtask

   task automatic test_random();
      desc_t d;
      int wb, eb, nexp;
      for (int n = 0; n < 25; n++) begin
         d = rand_desc($urandom_range(9) < 7);
         for (int i = 0; i < NB; i++) begin
            beat_data[i] = {$urandom, $urandom};
            beat_resp[i] = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            beat_last[i] = (i == NB - 1) ^ ($urandom_range(9) == 0);
         end
         wb   = got_wr.size();
         eb   = err_cycles;
         nexp = d.refill ? NB : 0;
         run_line(d, 30, 70, 1'b0, $urandom_range(2));
         checks++; if (timeout || out_desc !== d) begin errors++; $display("FAIL rnd%0d_desc: got %h expected %h", n, out_desc, d); end
         checks++; if (got_wr.size() - wb != nexp) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, got_wr.size() - wb, nexp); end
         for (int i = 0; i < nexp && wb + i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[wb + i] !== exp_wr(d, i)) begin errors++; $display("FAIL rnd%0d_wr%0d: got %h expected %h", n, i, got_wr[wb + i], exp_wr(d, i)); end
         end
         checks++;
         if (err_cycles - eb != (d.refill ? exp_errs() : 0)) begin
            errors++; $display("FAIL rnd%0d_err: got %0d expected %0d", n, err_cycles - eb, d.refill ? exp_errs() : 0);
         end
         checks++; if (mirror_bad != 0 || hold_bad != 0) begin errors++; $display("FAIL rnd%0d_handshake: got mirror %0d hold %0d expected 0", n, mirror_bad, hold_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_full_refill();
      test_backpressure();
      test_err_resp();
      test_last_err();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
